// File: rtl/universal_register_n.sv
// N-bit universal register: load, shift, rotate, inc/dec with optional saturation.
// Q and cout are registered; zero is decoded from Q.
module universal_register_n #(
  parameter int           N       = 4,
  parameter logic [N-1:0] RST_VAL = '0,
  parameter bit           SAT     = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [2:0]   mode,
  input  logic [N-1:0] D,
  input  logic         sin,
  output logic [N-1:0] Q,
  output logic         cout,
  output logic         zero
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROTL = 3'b100;
  localparam logic [2:0] M_ROTR = 3'b101;
  localparam logic [2:0] M_INC  = 3'b110;
  localparam logic [2:0] M_DEC  = 3'b111;

  logic [N-1:0] q_nxt;
  logic         c_nxt;
  logic [N:0]   sum, diff;

  // Extra bit carries out of inc and borrows out of dec.
  assign sum  = {1'b0, Q} + {{N{1'b0}}, 1'b1};
  assign diff = {1'b0, Q} - {{N{1'b0}}, 1'b1};

  always_comb begin
    q_nxt = Q;
    c_nxt = cout;
    case (mode)
      M_HOLD: ;
      M_LOAD: begin q_nxt = D;                    c_nxt = 1'b0; end
      M_SHL:  begin q_nxt = {Q[N-2:0], sin};      c_nxt = Q[N-1]; end
      M_SHR:  begin q_nxt = {sin, Q[N-1:1]};      c_nxt = Q[0]; end
      M_ROTL: begin q_nxt = {Q[N-2:0], Q[N-1]};   c_nxt = Q[N-1]; end
      M_ROTR: begin q_nxt = {Q[0], Q[N-1:1]};     c_nxt = Q[0]; end
      M_INC: begin
        if (SAT && sum[N]) begin q_nxt = Q;          c_nxt = 1'b1; end
        else               begin q_nxt = sum[N-1:0]; c_nxt = sum[N]; end
      end
      M_DEC: begin
        if (SAT && diff[N]) begin q_nxt = Q;           c_nxt = 1'b1; end
        else                begin q_nxt = diff[N-1:0]; c_nxt = diff[N]; end
      end
      default: ;
    endcase
  end

  // en gates the whole update so X on mode/D while disabled never reaches state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      Q    <= RST_VAL;
      cout <= 1'b0;
    end else if (en) begin
      Q    <= q_nxt;
      cout <= c_nxt;
    end
  end

  assign zero = (Q == '0);

endmodule

// File: tb/tb_universal_register_n.sv
// Bench for universal_register_n: two instances (wrap/RST_VAL=A, saturate/RST_VAL=0)
// driven in lockstep and checked against an arithmetic reference model.
module tb_universal_register_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, sin;
  logic [2:0] mode;
  logic [3:0] d;
  logic [3:0] q0, q1;
  logic       c0, c1, z0, z1;

  int mq[2];
  int mc[2];
  int n_chk  = 0;
  int n_fail = 0;

  universal_register_n #(.N(4), .RST_VAL(4'hA), .SAT(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .D(d), .sin(sin),
    .Q(q0), .cout(c0), .zero(z0));

  universal_register_n #(.N(4), .RST_VAL(4'h0), .SAT(1'b1)) u1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .D(d), .sin(sin),
    .Q(q1), .cout(c1), .zero(z1));

  // Reference: value semantics of each mode using plain integer arithmetic on 0..15.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int q, c, nq, nc, s;
      q = mq[i]; c = mc[i]; nq = q; nc = c;
      if (rst === 1'b0) begin
        nq = (i == 0) ? 10 : 0; nc = 0;
      end else if (en === 1'b1) begin
        s = (sin === 1'b1) ? 1 : 0;
        case (int'(mode))
          1: begin nq = int'(d); nc = 0; end
          2: begin nc = q / 8; nq = (q * 2) % 16 + s; end
          3: begin nc = q % 2; nq = q / 2 + 8 * s; end
          4: begin nc = q / 8; nq = (q * 2) % 16 + q / 8; end
          5: begin nc = q % 2; nq = q / 2 + 8 * (q % 2); end
          6: begin
            if (q == 15) begin nq = (i == 1) ? 15 : 0; nc = 1; end
            else begin nq = q + 1; nc = 0; end
          end
          7: begin
            if (q == 0) begin nq = (i == 1) ? 0 : 15; nc = 1; end
            else begin nq = q - 1; nc = 0; end
          end
          default: ;
        endcase
      end
      mq[i] = nq; mc[i] = nc;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic [3:0] dd, input logic s);
    rst = r; en = e; mode = m; d = dd; sin = s;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 3'b110, 4'h3, 1'b1);
    n_chk++;
    if ({q0, c0, z0} !== {4'hA, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_a: got Q=%h c=%b z=%b want Q=a c=0 z=0", q0, c0, z0);
    end
    n_chk++;
    if ({q1, c1, z1} !== {4'h0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_0: got Q=%h c=%b z=%b want Q=0 c=0 z=1", q1, c1, z1);
    end
  endtask

  task automatic test_load_hold();
    step(1'b1, 1'b1, 3'b001, 4'h5, 1'b0);
    n_chk++;
    if ({q0, c0, q1, c1} !== {4'h5, 1'b0, 4'h5, 1'b0}) begin
      n_fail++; $display("FAIL load: got Q=%h/%h c=%b/%b want Q=5 c=0", q0, q1, c0, c1);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 3'b001, 4'hF, 1'b1);
      n_chk++;
      if ({q0, q1} !== {4'h5, 4'h5}) begin
        n_fail++; $display("FAIL hold_en0[%0d]: got Q=%h/%h want 5", k, q0, q1);
      end
    end
    step(1'b1, 1'b0, 3'bxxx, 4'bxxxx, 1'bx);
    n_chk++;
    if ({q0, c0, q1, c1} !== {4'h5, 1'b0, 4'h5, 1'b0}) begin
      n_fail++; $display("FAIL hold_x: got Q=%h/%h c=%b/%b want Q=5 c=0", q0, q1, c0, c1);
    end
    step(1'b1, 1'b1, 3'b000, 4'hC, 1'b1);
    n_chk++;
    if ({q0, q1} !== {4'h5, 4'h5}) begin
      n_fail++; $display("FAIL mode_hold: got Q=%h/%h want 5", q0, q1);
    end
  endtask

  task automatic test_shift_rotate();
    logic [2:0] ops [4] = '{3'b010, 3'b011, 3'b101, 3'b100};
    logic       sins[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] eq  [4] = '{4'b0010, 4'b1001, 4'b1100, 4'b1001};
    logic       ec  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    step(1'b1, 1'b1, 3'b001, 4'b1001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, ops[k], 4'h0, sins[k]);
      n_chk++;
      if ({q0, c0, q1, c1} !== {eq[k], ec[k], eq[k], ec[k]}) begin
        n_fail++; $display("FAIL shift_rot[%0d]: got Q=%b/%b c=%b/%b want Q=%b c=%b",
                           k, q0, q1, c0, c1, eq[k], ec[k]);
      end
    end
  endtask

  task automatic test_wrap_count();
    logic [2:0] ops[4] = '{3'b110, 3'b110, 3'b111, 3'b111};
    logic [3:0] eq [4] = '{4'hF, 4'h0, 4'hF, 4'hE};
    logic       ec [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    step(1'b1, 1'b1, 3'b001, 4'hE, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, ops[k], 4'h0, 1'b0);
      n_chk++;
      if ({q0, c0, z0} !== {eq[k], ec[k], eq[k] == 4'h0}) begin
        n_fail++; $display("FAIL wrap[%0d]: got Q=%h c=%b z=%b want Q=%h c=%b",
                           k, q0, c0, z0, eq[k], ec[k]);
      end
      n_chk++;
      if ({q1, c1} !== {4'(mq[1]), 1'(mc[1])}) begin
        n_fail++; $display("FAIL wrap_sat[%0d]: got Q=%h c=%b want Q=%h c=%0d", k, q1, c1, mq[1], mc[1]);
      end
    end
  endtask

  task automatic test_saturate();
    step(1'b1, 1'b1, 3'b001, 4'hF, 1'b0);
    step(1'b1, 1'b1, 3'b110, 4'h0, 1'b0);
    n_chk++;
    if ({q1, c1, q0, c0} !== {4'hF, 1'b1, 4'h0, 1'b1}) begin
      n_fail++; $display("FAIL sat_inc: got Q=%h/%h c=%b/%b want sat F,1 wrap 0,1", q1, q0, c1, c0);
    end
    step(1'b1, 1'b1, 3'b001, 4'h0, 1'b0);
    step(1'b1, 1'b1, 3'b111, 4'h0, 1'b0);
    n_chk++;
    if ({q1, c1, z1, q0, c0} !== {4'h0, 1'b1, 1'b1, 4'hF, 1'b1}) begin
      n_fail++; $display("FAIL sat_dec: got Q=%h/%h c=%b/%b z=%b want sat 0,1 wrap F,1", q1, q0, c1, c0, z1);
    end
    step(1'b1, 1'b1, 3'b110, 4'h0, 1'b0);
    n_chk++;
    if ({q1, c1} !== {4'h1, 1'b0}) begin
      n_fail++; $display("FAIL sat_inc0: got Q=%h c=%b want Q=1 c=0", q1, c1);
    end
  endtask

  task automatic test_reset_mid_count();
    step(1'b1, 1'b1, 3'b001, 4'h3, 1'b0);
    step(1'b1, 1'b1, 3'b110, 4'h0, 1'b0);
    step(1'b1, 1'b1, 3'b110, 4'h0, 1'b0);
    n_chk++;
    if ({q0, q1} !== {4'h5, 4'h5}) begin
      n_fail++; $display("FAIL count_pre: got Q=%h/%h want 5", q0, q1);
    end
    step(1'b0, 1'b1, 3'b110, 4'h0, 1'b0);
    n_chk++;
    if ({q0, c0, q1, c1} !== {4'hA, 1'b0, 4'h0, 1'b0}) begin
      n_fail++; $display("FAIL rst_mid: got Q=%h/%h c=%b/%b want Q=a/0 c=0", q0, q1, c0, c1);
    end
    step(1'b1, 1'b1, 3'b110, 4'h0, 1'b0);
    n_chk++;
    if ({q0, q1} !== {4'hB, 4'h1}) begin
      n_fail++; $display("FAIL count_resume: got Q=%h/%h want b/1", q0, q1);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
           3'($urandom), 4'($urandom), 1'($urandom));
      n_chk++;
      if ({q0, c0, z0} !== {4'(mq[0]), 1'(mc[0]), mq[0] == 0}) begin
        n_fail++; $display("FAIL rand_wrap[%0d]: got Q=%h c=%b z=%b want Q=%h c=%0d", k, q0, c0, z0, mq[0], mc[0]);
      end
      n_chk++;
      if ({q1, c1, z1} !== {4'(mq[1]), 1'(mc[1]), mq[1] == 0}) begin
        n_fail++; $display("FAIL rand_sat[%0d]: got Q=%h c=%b z=%b want Q=%h c=%0d", k, q1, c1, z1, mq[1], mc[1]);
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode = 3'b000; d = 4'h0; sin = 1'b0;
    mq[0] = 0; mq[1] = 0; mc[0] = 0; mc[1] = 0;
    #2;
    test_reset();
    test_load_hold();
    test_shift_rotate();
    test_wrap_count();
    test_saturate();
    test_reset_mid_count();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
